// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg: shared encodings for the memory bus arbiter.
//   arb_state_e : 3-bit arbiter FSM state encoding
//   ZeroWord    : 32-bit zero used for reset and aborted-read data
//   Stop/NoStop : stall request levels seen by the pipeline stall controller
//   RstEnable   : asserted level of the active-low reset
package mem_bus_arbiter_pkg;

   typedef enum logic [2:0] {
      ArbIdle    = 3'd0,
      ArbMemAcc  = 3'd1,
      ArbMemDone = 3'd2,
      ArbIfAcc   = 3'd3,
      ArbIfDone  = 3'd4,
      ArbIfDrain = 3'd5
   } arb_state_e;

   localparam logic [31:0] ZeroWord  = 32'h0000_0000;
   localparam logic        Stop      = 1'b1;
   localparam logic        NoStop    = 1'b0;
   localparam logic        RstEnable = 1'b0;

   localparam int unsigned WdogWidth = 8;
   localparam logic [3:0]  SelWord   = 4'b1111;
   localparam logic [3:0]  SelNone   = 4'b0000;

endpackage

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: serialises the IF-stage fetch and MEM-stage load/store onto one shared
// memory bus, MEM having priority. A transaction FSM drives the registered bus outputs, a
// watchdog aborts accesses the slave never acknowledges, and fetches killed by a flush are
// drained off the bus and discarded.
//
// Ports
//   clk, rst            : clock, asynchronous active-low reset
//   flush               : exception flush, kills an in-flight or pending fetch
//   if_req/if_addr      : fetch request and word address; if_rdata returns the instruction
//   stallreq_from_pc    : IF stall request
//   mem_req/we/sel/addr/wdata : data access request; mem_rdata returns load data
//   stallreq_from_mem   : MEM stall request
//   bus_cyc/we/sel/addr/wdata : registered bus master outputs
//   bus_rdata/bus_ack   : slave read data and completion
//   bus_err             : one-cycle pulse when the watchdog aborts an access
module mem_bus_arbiter
   import mem_bus_arbiter_pkg::*;
#(
   // Must not exceed 255 (8-bit watchdog); 0 disables the watchdog.
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        stallreq_from_pc,
   input  logic        mem_req,
   input  logic        mem_we,
   input  logic [3:0]  mem_sel,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   output logic [31:0] mem_rdata,
   output logic        stallreq_from_mem,
   output logic        bus_cyc,
   output logic        bus_we,
   output logic [3:0]  bus_sel,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   input  logic [31:0] bus_rdata,
   input  logic        bus_ack,
   output logic        bus_err
);

   // Counter value seen in the last waiting cycle before the abort.
   localparam logic [WdogWidth-1:0] WdogLast =
      (TIMEOUT_CYCLES == 0) ? '0 : WdogWidth'(TIMEOUT_CYCLES - 1);

   arb_state_e           r_state,     w_state_nxt;
   logic                 r_bus_cyc,   w_bus_cyc_nxt;
   logic                 r_bus_we,    w_bus_we_nxt;
   logic [3:0]           r_bus_sel,   w_bus_sel_nxt;
   logic [31:0]          r_bus_addr,  w_bus_addr_nxt;
   logic [31:0]          r_bus_wdata, w_bus_wdata_nxt;
   logic [31:0]          r_if_rdata,  w_if_rdata_nxt;
   logic [31:0]          r_mem_rdata, w_mem_rdata_nxt;
   logic                 r_bus_err,   w_bus_err_nxt;
   logic                 r_kill,      w_kill_nxt;
   logic [WdogWidth-1:0] r_wdog,      w_wdog_nxt;

   logic                 w_timeout;
   logic                 w_done;
   logic [31:0]          w_ack_data;

   // Ack wins over a coincident timeout; an aborted access returns zero data.
   assign w_timeout  = (TIMEOUT_CYCLES != 0) && !bus_ack && (r_wdog == WdogLast);
   assign w_done     = bus_ack || w_timeout;
   assign w_ack_data = w_timeout ? ZeroWord : bus_rdata;

   always_comb begin
      w_state_nxt     = r_state;
      w_bus_cyc_nxt   = r_bus_cyc;
      w_bus_we_nxt    = r_bus_we;
      w_bus_sel_nxt   = r_bus_sel;
      w_bus_addr_nxt  = r_bus_addr;
      w_bus_wdata_nxt = r_bus_wdata;
      w_if_rdata_nxt  = r_if_rdata;
      w_mem_rdata_nxt = r_mem_rdata;
      w_bus_err_nxt   = 1'b0;
      w_kill_nxt      = r_kill;
      w_wdog_nxt      = r_wdog;

      unique case (r_state)
         ArbIdle: begin
            // Holding the counter at zero here clears it on entry to either *_ACC state.
            w_kill_nxt = 1'b0;
            w_wdog_nxt = '0;
            if (mem_req) begin
               w_bus_cyc_nxt   = 1'b1;
               w_bus_we_nxt    = mem_we;
               w_bus_sel_nxt   = mem_sel;
               w_bus_addr_nxt  = mem_addr;
               w_bus_wdata_nxt = mem_wdata;
               w_state_nxt     = ArbMemAcc;
            end else if (if_req && !flush) begin
               w_bus_cyc_nxt  = 1'b1;
               w_bus_we_nxt   = 1'b0;
               w_bus_sel_nxt  = SelWord;
               w_bus_addr_nxt = if_addr;
               w_state_nxt    = ArbIfAcc;
            end
         end

         ArbMemAcc: begin
            // Flush is deliberately ignored: a started data access always completes.
            if (w_done) begin
               w_mem_rdata_nxt = w_ack_data;
               w_bus_cyc_nxt   = 1'b0;
               w_bus_we_nxt    = 1'b0;
               w_bus_sel_nxt   = SelNone;
               w_bus_err_nxt   = w_timeout;
               w_state_nxt     = ArbMemDone;
            end else begin
               w_wdog_nxt = r_wdog + WdogWidth'(1);
            end
         end

         ArbMemDone: w_state_nxt = ArbIdle;

         ArbIfAcc: begin
            if (w_done) begin
               w_bus_cyc_nxt = 1'b0;
               w_bus_we_nxt  = 1'b0;
               w_bus_sel_nxt = SelNone;
               w_bus_err_nxt = w_timeout;
               w_kill_nxt    = 1'b0;
               if (flush || r_kill) begin
                  w_state_nxt = ArbIdle;
               end else begin
                  w_if_rdata_nxt = w_ack_data;
                  w_state_nxt    = ArbIfDone;
               end
            end else if (flush) begin
               // The slave still owes an ack; keep the bus up and drop the data later.
               w_kill_nxt  = 1'b1;
               w_wdog_nxt  = '0;
               w_state_nxt = ArbIfDrain;
            end else begin
               w_wdog_nxt = r_wdog + WdogWidth'(1);
            end
         end

         ArbIfDone: w_state_nxt = ArbIdle;

         ArbIfDrain: begin
            if (w_done) begin
               w_bus_cyc_nxt = 1'b0;
               w_bus_we_nxt  = 1'b0;
               w_bus_sel_nxt = SelNone;
               w_bus_err_nxt = w_timeout;
               w_kill_nxt    = 1'b0;
               w_state_nxt   = ArbIdle;
            end else begin
               w_wdog_nxt = r_wdog + WdogWidth'(1);
            end
         end

         default: w_state_nxt = ArbIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (rst == RstEnable) begin
         r_state     <= ArbIdle;
         r_bus_cyc   <= 1'b0;
         r_bus_we    <= 1'b0;
         r_bus_sel   <= SelNone;
         r_bus_addr  <= ZeroWord;
         r_bus_wdata <= ZeroWord;
         r_if_rdata  <= ZeroWord;
         r_mem_rdata <= ZeroWord;
         r_bus_err   <= 1'b0;
         r_kill      <= 1'b0;
         r_wdog      <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_bus_cyc   <= w_bus_cyc_nxt;
         r_bus_we    <= w_bus_we_nxt;
         r_bus_sel   <= w_bus_sel_nxt;
         r_bus_addr  <= w_bus_addr_nxt;
         r_bus_wdata <= w_bus_wdata_nxt;
         r_if_rdata  <= w_if_rdata_nxt;
         r_mem_rdata <= w_mem_rdata_nxt;
         r_bus_err   <= w_bus_err_nxt;
         r_kill      <= w_kill_nxt;
         r_wdog      <= w_wdog_nxt;
      end
   end

   // The requester is released only in its own DONE cycle; a drained fetch keeps IF stalled.
   assign stallreq_from_mem = (mem_req && (r_state != ArbMemDone)) ? Stop : NoStop;
   assign stallreq_from_pc  = ((if_req && (r_state != ArbIfDone)) || (r_state == ArbIfDrain))
                              ? Stop : NoStop;

   assign bus_cyc   = r_bus_cyc;
   assign bus_we    = r_bus_we;
   assign bus_sel   = r_bus_sel;
   assign bus_addr  = r_bus_addr;
   assign bus_wdata = r_bus_wdata;
   assign bus_err   = r_bus_err;
   assign if_rdata  = r_if_rdata;
   assign mem_rdata = r_mem_rdata;

endmodule
